// File: rtl/mux_4x1_scan_ctrl_if.sv
// Handshake and data bundle between the scan controller, the external 4:1 mux and the word consumer.
interface mux_4x1_scan_ctrl_if;
  logic       start;
  logic       cont;
  logic       mux_y;
  logic [1:0] sel_out;
  logic [3:0] data_out;
  logic       valid;
  logic       ready;
  logic       busy;
  logic [7:0] word_cnt;

  // master: requester/consumer side (also models the mux)
  modport master (
    output start, cont, mux_y, ready,
    input  sel_out, data_out, valid, busy, word_cnt
  );

  // slave: the scan controller
  modport slave (
    input  start, cont, mux_y, ready,
    output sel_out, data_out, valid, busy, word_cnt
  );
endinterface

// File: rtl/mux_4x1_scan_ctrl.sv
// Steps the select of an external 4:1 mux through all four channels, samples its output after
// a settle time per channel and presents the assembled 4-bit word with a valid/ready handshake.
module mux_4x1_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_4x1_scan_ctrl_if.slave   bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned WCNT_W = 8;

  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [WCNT_W-1:0]   word_q, word_d;

  // State and datapath registers; every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      word_q   <= word_d;
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    word_d   = word_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCAN;
          sel_d   = '0;
          cnt_d   = RELOAD;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end

      SCAN: begin
        if (cnt_q != '0) begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end else begin
          shadow_d[sel_q] = bus.mux_y;
          if (sel_q != SEL_LAST) begin
            sel_d = SEL_W'(sel_q + SEL_W'(1));
            cnt_d = RELOAD;
          end else begin
            // Whole word lands at once so data_out never shows a partial scan.
            data_d  = {bus.mux_y, shadow_q[DATA_W-2:0]};
            valid_d = 1'b1;
            busy_d  = 1'b0;
            sel_d   = '0;
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (bus.ready) begin
          word_d  = WCNT_W'(word_q + WCNT_W'(1));
          valid_d = 1'b0;
          if (bus.cont) begin
            state_d = SCAN;
            sel_d   = '0;
            cnt_d   = RELOAD;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.sel_out  = sel_q;
  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.word_cnt = word_q;

endmodule

// File: doc/mux_4x1_scan_ctrl.md
MUX_4X1_SCAN_CTRL -- requirements
Module: mux_4x1_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 1: clock cycles the select is held per channel before sampling; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request one 4-channel scan; sampled only in IDLE.
REQ-005 cont  input  1  continuous mode; sampled at each word handshake.
REQ-006 mux_y  input  1  output Y of the downstream 4:1 mux.
REQ-007 sel_out  output  2  select driven to the 4:1 mux, S[1:0].
REQ-008 data_out  output  4  captured word, bit i = mux_y sampled while sel_out = i.
REQ-009 valid  output  1  data_out holds a complete, unconsumed word.
REQ-010 ready  input  1  consumer accepts data_out when valid=1 and ready=1 on the same edge.
REQ-011 busy  output  1  scan in progress (state SCAN).
REQ-012 word_cnt  output  8  count of accepted words.

Function
REQ-013 FSM states SHALL be IDLE, SCAN and HOLD; registered outputs only, no combinational path from any input to any output.
REQ-014 IDLE: sel_out=0, busy=0, valid=0; start=1 -> SCAN with sel_out=0 and settle counter loaded to SETTLE-1.
REQ-015 SCAN: busy=1; each cycle, counter!=0 -> decrement; counter==0 -> capture mux_y into shadow bit [sel_out].
REQ-016 SCAN capture with sel_out<3 -> sel_out+1, counter reloaded to SETTLE-1, remain in SCAN.
REQ-017 SCAN capture with sel_out==3 -> data_out loaded with all 4 shadow bits (bit 3 = current mux_y), valid=1, busy=0, sel_out=0, -> HOLD.
REQ-018 Latency: valid SHALL rise exactly 4*SETTLE cycles after the edge that samples start=1.
REQ-019 data_out SHALL change only on the REQ-017 edge; it SHALL NOT show partially scanned words.
REQ-020 HOLD: valid=1, data_out stable while ready=0, for any number of cycles.
REQ-021 HOLD with ready=1: word_cnt+1 (modulo 256, 255->0); cont=1 -> SCAN with sel_out=0 and counter=SETTLE-1, valid=0; cont=0 -> IDLE, valid=0.
REQ-022 start SHALL be ignored in SCAN and HOLD; ready SHALL be ignored outside HOLD.
REQ-023 cont deasserted during SCAN SHALL NOT abort the scan; it takes effect at the next handshake.
REQ-024 sel_out SHALL only step 0->1->2->3 within a scan and return to 0; the value 3 SHALL NOT wrap to 0 without a capture.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, sel_out=0, data_out=0, valid=0, busy=0, word_cnt=0, shadow bits=0, counter=0, independent of clk.
REQ-026 rst asserted mid-SCAN or in HOLD SHALL discard the partial or pending word; no handshake is counted.
REQ-027 After rst deasserts, the first scan SHALL start only on a new start=1 sampled in IDLE.

Verification
REQ-028 SETTLE=1, bench mux model I=4'b1010, pulse start with cont=0 and ready=1 -> sel_out 0,1,2,3 on consecutive cycles; valid rises 4 cycles after start; data_out=4'b1010; word_cnt=1; returns to IDLE.
REQ-029 SETTLE=3, I=4'b0110, ready=0 for 10 cycles after valid -> valid rises 12 cycles after start; data_out=4'b0110 and valid=1 held stable for all 10 cycles; word_cnt stays 0 until ready=1.
REQ-030 cont=1, ready=1, I changed 4'b0001 -> 4'b1110 between scans -> back-to-back words 4'b0001 then 4'b1110 with no IDLE cycle; word_cnt increments by 1 per word.
REQ-031 start pulsed during SCAN, ready toggled in IDLE -> no second scan launched, word_cnt unchanged, sel_out sequence undisturbed.
REQ-032 rst asserted between clock edges while sel_out=2 -> all outputs at reset values before the next edge; a subsequent start yields a complete, correct word.
REQ-033 cont=1, ready=1 held for 256 words -> word_cnt wraps 255->0 and continues counting.
